// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the synchronous memory blocks.
//   ram_state_t   - clear sequencer state encoding (CLEAR, IDLE)
//   addr_in_range - in-range compare (addr < depth), shared with the ROM and
//                   other memory blocks
//   idx_width     - index width needed to address a storage array of 'depth'
//                   words (never less than 1)
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } ram_state_t;

  // Both operands are zero-extended to 32 bits by the caller, so a single
  // definition serves every address width.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] depth);
    return (addr < depth);
  endfunction

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// ram_clear_seq: post-reset clear sequencer for ram_sync.
// After reset it walks the pointer from 0 to DEPTH-1, one word per rising
// edge, then parks in IDLE.
// Ports:
//   clk      - clock
//   reset    - asynchronous, active-high; restarts the walk from word 0
//   wr_addr  - word being cleared on this edge
//   wr_en    - clear write strobe (high throughout CLEAR)
//   done     - clear finished, normal accesses may proceed
//   busy     - registered busy flag, high from reset until the last word
//              has been written
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic             clk,
  input  logic             reset,
  output logic [IDX_W-1:0] wr_addr,
  output logic             wr_en,
  output logic             done,
  output logic             busy
);

  // One extra pointer bit so DEPTH = 2^ADDR_W reaches its last word without
  // the pointer wrapping back to zero first.
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] STEP = (ADDR_W + 1)'(1);

  ram_state_t      state;
  logic [ADDR_W:0] clr_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + STEP;
          if (clr_ptr == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign wr_addr = clr_ptr[IDX_W-1:0];
  assign wr_en   = (state == CLEAR);
  assign done    = (state == IDLE);

endmodule

// File: rtl/ram_sync.sv
// ram_sync: parametrised single-port synchronous RAM on a shared
// bidirectional data bus.
// Build option: RAM_CLEAR_EN - when defined, a clear sequencer writes
// INIT_VAL to every word after reset and holds busy high until done; when
// undefined the block leaves reset directly ready and memory starts unknown.
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - asynchronous, active-high
//   addr   - word address
//   we     - write enable, has priority over a read
//   oe     - output enable for the data bus
//   data   - bidirectional data bus, driven only for oe & ~we & ~busy
//   busy   - clear in progress, accesses ignored
//   rvalid - one-cycle pulse: read buffer loaded on this edge for an oe read
//   err    - one-cycle pulse: access on this edge had addr >= DEPTH
module ram_sync
  import ram_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 64,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic              oe,
  inout  wire  [DATA_W-1:0] data,
  output logic              busy,
  output logic              rvalid,
  output logic              err
);

  localparam int IDX_W = idx_width(DEPTH);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic [DATA_W-1:0] rd_buf_p1;
  logic              rvalid_p1;
  logic              err_p1;

  logic              clr_we;
  logic [IDX_W-1:0]  clr_addr;
  logic              acc_en;
  logic              in_rng;
  logic [IDX_W-1:0]  acc_idx;
  logic              bus_drive;

`ifdef RAM_CLEAR_EN
  logic clr_done;
  logic clr_busy;

  ram_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_clear (
    .clk     (clk),
    .reset   (reset),
    .wr_addr (clr_addr),
    .wr_en   (clr_we),
    .done    (clr_done),
    .busy    (clr_busy)
  );

  assign acc_en = clr_done;
  assign busy   = clr_busy;
`else
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
  assign acc_en   = 1'b1;
  assign busy     = 1'b0;
`endif

  assign in_rng  = addr_in_range(32'(addr), 32'(DEPTH));
  // Only meaningful when in_rng is true; out-of-range addresses never reach
  // the array.
  assign acc_idx = addr[IDX_W-1:0];

  // Storage: clear writes own the port while the sequencer runs.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= INIT_VAL;
    end else if (acc_en && we && in_rng) begin
      mem[acc_idx] <= data;
    end
  end

  // Stage p1: read buffer and status pulses, one edge after sampling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_buf_p1 <= '0;
      rvalid_p1 <= 1'b0;
      err_p1    <= 1'b0;
    end else begin
      rvalid_p1 <= 1'b0;
      err_p1    <= 1'b0;
      if (acc_en) begin
        if (we) begin
          err_p1 <= ~in_rng;
        end else begin
          rd_buf_p1 <= in_rng ? mem[acc_idx] : '0;
          err_p1    <= ~in_rng;
          rvalid_p1 <= oe;
        end
      end
    end
  end

  // Bus drive is combinational so oe alone opens or closes the driver
  // without disturbing the buffer.
  assign bus_drive = oe & ~we & ~busy;
  assign data      = bus_drive ? rd_buf_p1 : 'z;

  assign rvalid = rvalid_p1;
  assign err    = err_p1;

endmodule

// File: tb/tb_ram_sync.sv
// tb_ram_sync: scoreboard bench for ram_sync. Two instances share clk and
// reset: u_main (DEPTH=64) and u_big (DEPTH=256, full address space), both
// with INIT_VAL=8'hA5. Stimulus tasks push the hand-computed response of
// every access that should pulse rvalid or err; monitors pop and compare on
// each pulse. Covers RAM_CLEAR_EN defined or undefined.
module tb_ram_sync;

  localparam logic [7:0] INIT = 8'hA5;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] addr_m = '0, addr_b = '0;
  logic       we_m = 1'b0, oe_m = 1'b0, we_b = 1'b0, oe_b = 1'b0;
  logic       drv_m = 1'b0, drv_b = 1'b0;
  logic [7:0] val_m = '0, val_b = '0;
  wire  [7:0] data_m, data_b;
  logic       busy_m, rvalid_m, err_m, busy_b, rvalid_b, err_b;

  assign data_m = drv_m ? val_m : 'z;
  assign data_b = drv_b ? val_b : 'z;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic       rv;
    logic       er;
    logic [7:0] d;
  } exp_t;

  exp_t qm[$];
  exp_t qb[$];
  exp_t em, eb;

  always #5 clk = ~clk;

  ram_sync #(.DATA_W(8), .ADDR_W(8), .DEPTH(64), .INIT_VAL(INIT)) u_main (
    .clk(clk), .reset(reset), .addr(addr_m), .we(we_m), .oe(oe_m),
    .data(data_m), .busy(busy_m), .rvalid(rvalid_m), .err(err_m)
  );

  ram_sync #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .INIT_VAL(INIT)) u_big (
    .clk(clk), .reset(reset), .addr(addr_b), .we(we_b), .oe(oe_b),
    .data(data_b), .busy(busy_b), .rvalid(rvalid_b), .err(err_b)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_wr(input bit big, input logic [7:0] a,
                          input logic [7:0] d, input logic oe,
                          input bit exp_err);
    exp_t e;
    e.rv = 1'b0;
    e.er = 1'b1;
    e.d  = 8'h00;
    if (!big) begin
      addr_m = a; we_m = 1'b1; oe_m = oe; drv_m = 1'b1; val_m = d;
      if (exp_err) qm.push_back(e);
    end else begin
      addr_b = a; we_b = 1'b1; oe_b = oe; drv_b = 1'b1; val_b = d;
      if (exp_err) qb.push_back(e);
    end
  endtask

  task automatic drive_rd(input bit big, input logic [7:0] a, input logic oe,
                          input logic [7:0] exp_d, input bit exp_err);
    exp_t e;
    e.rv = oe;
    e.er = exp_err;
    e.d  = exp_d;
    if (!big) begin
      addr_m = a; we_m = 1'b0; oe_m = oe; drv_m = 1'b0;
      if (oe || exp_err) qm.push_back(e);
    end else begin
      addr_b = a; we_b = 1'b0; oe_b = oe; drv_b = 1'b0;
      if (oe || exp_err) qb.push_back(e);
    end
  endtask

  task automatic wr(input bit big, input logic [7:0] a, input logic [7:0] d,
                    input logic oe, input bit exp_err);
    @(negedge clk);
    drive_wr(big, a, d, oe, exp_err);
    @(posedge clk);
  endtask

  task automatic rd(input bit big, input logic [7:0] a, input logic oe,
                    input logic [7:0] exp_d, input bit exp_err);
    @(negedge clk);
    drive_rd(big, a, oe, exp_d, exp_err);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    we_m = 1'b0; oe_m = 1'b0; drv_m = 1'b0; addr_m = '0;
    we_b = 1'b0; oe_b = 1'b0; drv_b = 1'b0; addr_b = '0;
  endtask

  // Counts edges until each busy falls; a pending write on u_main is
  // withdrawn as soon as its clear finishes.
  task automatic wait_clear(output int nm, output int nb);
    nm = -1;
    nb = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      #1;
      if (nm < 0 && !busy_m) begin
        nm = i;
        we_m = 1'b0; drv_m = 1'b0;
      end
      if (nb < 0 && !busy_b) nb = i;
      if (nm >= 0 && nb >= 0) break;
    end
  endtask

  // Monitors
  always @(posedge clk) begin
    #1;
`ifndef RAM_CLEAR_EN
    chk("busy_tied_main", 32'(busy_m), 32'd0);
    chk("busy_tied_big", 32'(busy_b), 32'd0);
`endif
    if (!reset && (rvalid_m || err_m)) begin
      if (qm.size() == 0) begin
        chk("main_spurious_pulse", 32'({rvalid_m, err_m}), 32'd0);
      end else begin
        em = qm.pop_front();
        chk("main_rvalid", 32'(rvalid_m), 32'(em.rv));
        chk("main_err", 32'(err_m), 32'(em.er));
        if (em.rv) chk("main_rdata", 32'(data_m), 32'(em.d));
      end
    end
    if (!reset && (rvalid_b || err_b)) begin
      if (qb.size() == 0) begin
        chk("big_spurious_pulse", 32'({rvalid_b, err_b}), 32'd0);
      end else begin
        eb = qb.pop_front();
        chk("big_rvalid", 32'(rvalid_b), 32'(eb.rv));
        chk("big_err", 32'(err_b), 32'(eb.er));
        if (eb.rv) chk("big_rdata", 32'(data_b), 32'(eb.d));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nm, nb;
`ifdef RAM_CLEAR_EN
    // Reset and full clear of both instances.
    #12;
    chk("reset_busy_main", 32'(busy_m), 32'd1);
    chk("reset_busy_big", 32'(busy_b), 32'd1);
    chk("reset_rvalid", 32'(rvalid_m), 32'd0);
    chk("reset_err", 32'(err_m), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_clear(nm, nb);
    chk("clear_len_main", 32'(nm), 32'd64);
    chk("clear_len_big", 32'(nb), 32'd256);
`else
    // No sequencer: buffer drives its reset value of 0 while oe is high.
    oe_m = 1'b1;
    oe_b = 1'b1;
    #12;
    chk("reset_busy_main", 32'(busy_m), 32'd0);
    chk("reset_rvalid", 32'(rvalid_m), 32'd0);
    chk("reset_err", 32'(err_m), 32'd0);
    chk("reset_buf_main", 32'(data_m), 32'd0);
    chk("reset_buf_big", 32'(data_b), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    oe_b = 1'b0;
    drive_wr(1'b0, 8'd7, 8'h42, 1'b0, 1'b0);
    @(posedge clk);
    rd(1'b0, 8'd7, 1'b1, 8'h42, 1'b0);
    wr(1'b0, 8'd0, INIT, 1'b0, 1'b0);
    wr(1'b0, 8'd31, INIT, 1'b0, 1'b0);
    wr(1'b0, 8'd63, INIT, 1'b0, 1'b0);
`endif

    rd(1'b0, 8'd0, 1'b1, INIT, 1'b0);
    rd(1'b0, 8'd31, 1'b1, INIT, 1'b0);
    rd(1'b0, 8'd63, 1'b1, INIT, 1'b0);

    // Write with oe high: the bench must be the only driver.
    wr(1'b0, 8'd5, 8'h3C, 1'b1, 1'b0);
    #1;
    chk("bus_released_during_we", 32'(data_m), 32'h3C);
    rd(1'b0, 8'd5, 1'b1, 8'h3C, 1'b0);

    // Out-of-range write dropped, out-of-range reads return 0.
    wr(1'b0, 8'd64, 8'hFF, 1'b0, 1'b1);
    rd(1'b0, 8'd0, 1'b1, INIT, 1'b0);
    rd(1'b0, 8'd64, 1'b1, 8'h00, 1'b1);
    rd(1'b0, 8'd100, 1'b0, 8'h00, 1'b1);

    // Silent read, then oe raised between edges exposes the buffer.
    rd(1'b0, 8'd5, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    oe_m = 1'b1;
    #1;
    chk("oe_toggle_drive", 32'(data_m), 32'h3C);
    oe_m = 1'b0;

`ifdef RAM_CLEAR_EN
    // Reset in the middle of a clear restarts it from word 0.
    wr(1'b0, 8'd3, 8'h77, 1'b0, 1'b0);
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midclear_busy", 32'(busy_m), 32'd1);
    chk("midclear_rvalid", 32'(rvalid_m), 32'd0);
    chk("midclear_err", 32'(err_m), 32'd0);
    @(negedge clk);
    addr_m = 8'd3; we_m = 1'b1; drv_m = 1'b1; val_m = 8'h11; oe_m = 1'b0;
    reset = 1'b0;
    wait_clear(nm, nb);
    chk("reclear_len_main", 32'(nm), 32'd64);
    chk("reclear_len_big", 32'(nb), 32'd256);
    rd(1'b0, 8'd3, 1'b1, INIT, 1'b0);
    rd(1'b1, 8'd0, 1'b1, INIT, 1'b0);
`endif

    // Full address space: top word is in range.
    wr(1'b1, 8'd255, 8'h5A, 1'b0, 1'b0);
    rd(1'b1, 8'd255, 1'b1, 8'h5A, 1'b0);
    wr(1'b1, 8'd128, 8'hC3, 1'b0, 1'b0);
    rd(1'b1, 8'd128, 1'b1, 8'hC3, 1'b0);

    idle();
    repeat (3) @(posedge clk);
    #2;
    chk("main_queue_drained", 32'(qm.size()), 32'd0);
    chk("big_queue_drained", 32'(qb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
